// File: rtl/bsearch_pkg.sv
// bsearch_pkg: shared state encoding, midpoint helper and flag-check constant for the binary-search seeker
package bsearch_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int FLAG_ONEHOT = 1;
  function automatic logic [32:0] mid(input logic [31:0] lo, input logic [31:0] hi);
    return {1'b0, lo} + (({1'b0, hi} - {1'b0, lo}) >> 1);
  endfunction
endpackage

// File: rtl/bsearch_watchdog.sv
// bsearch_watchdog: counts unanswered wait cycles and flags expiry on the TIMEOUT-th one
module bsearch_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  // cleared while the next guess is being issued, advances on each silent wait cycle
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = en && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/bsearch_seeker.sv
// bsearch_seeker: binary-searches a hidden target through an external comparator; BSEARCH_TIMEOUT_EN adds a response watchdog
module bsearch_seeker
  import bsearch_pkg::*;
#(
  parameter int N       = 12,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N-1:0]     guess,
  output logic             guess_valid,
  input  logic             resp_valid,
  input  logic             smaller,
  input  logic             equal,
  input  logic             greater,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [N-1:0]     result,
  output logic [CNT_W-1:0] iter_count
);
  state_t       state;
  logic [N-1:0] lo, hi;
  logic         timeout, one_hot, finish;
  if (CNT_W < $clog2(N + 2) || TIMEOUT < 1) begin : g_bad_cfg
    $error("bsearch_seeker: CNT_W too narrow or TIMEOUT below 1");
  end
`ifdef BSEARCH_TIMEOUT_EN
  bsearch_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ISSUE),
    .en      (state == WAIT && !resp_valid),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  assign one_hot = $countones({smaller, equal, greater}) == FLAG_ONEHOT;
  assign finish  = !one_hot || equal || (greater && guess == lo) || (smaller && guess == hi);
  // search FSM with registered outputs; bounds checks stop lo/hi from wrapping
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      lo          <= '0;
      hi          <= '0;
      guess       <= '0;
      guess_valid <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      iter_count  <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            state      <= ISSUE;
            lo         <= '0;
            hi         <= '1;
            iter_count <= '0;
            done       <= 1'b0;
            found      <= 1'b0;
            err        <= 1'b0;
            result     <= '0;
          end
        ISSUE: begin
          guess       <= N'(mid(32'(lo), 32'(hi)));
          guess_valid <= 1'b1;
          state       <= WAIT;
        end
        WAIT:
          if (resp_valid) begin
            iter_count  <= iter_count + 1'b1;
            guess_valid <= 1'b0;
            if (finish) begin
              state  <= DONE;
              done   <= 1'b1;
              err    <= !one_hot;
              found  <= one_hot && equal;
              result <= (one_hot && equal) ? guess : '0;
            end else begin
              state <= ISSUE;
              if (greater) hi <= guess - 1'b1;
              else lo <= guess + 1'b1;
            end
          end else if (timeout) begin
            state       <= DONE;
            done        <= 1'b1;
            err         <= 1'b1;
            guess_valid <= 1'b0;
          end
      endcase
endmodule

// File: tb/tb_bsearch_seeker.sv
// tb_bsearch_seeker: randomized comparator responder checked against a queue-based search model
module tb_bsearch_seeker;
  localparam int N  = 12;
  localparam int TO = 64;
  logic clk, rst, start, resp_valid, smaller, equal, greater;
  logic [N-1:0] guess, result;
  logic guess_valid, done, found, err;
  logic [7:0] iter_count;
  int total = 0, bad = 0;
  int exp_q[$];
  int exp_n, exp_found, exp_err, exp_res;
  int target = 0, md = 0, dly = 0;
  bit gv_en = 0, gv_prev = 0, done_prev = 0;

  bsearch_seeker #(.N(N), .CNT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .guess(guess), .guess_valid(guess_valid),
    .resp_valid(resp_valid), .smaller(smaller), .equal(equal), .greater(greater),
    .done(done), .found(found), .err(err), .result(result), .iter_count(iter_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: plain binary search over 0..4095; mode 1 = comparator always says greater, mode 2 = illegal flags
  task automatic model(input int tgt, input int mode);
    int lo = 0, hi = (1 << N) - 1, g;
    exp_q.delete();
    exp_n = 0; exp_found = 0; exp_err = 0; exp_res = 0;
    forever begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      exp_n++;
      if (mode == 2) begin exp_err = 1; break; end
      if (mode == 1 || g > tgt) begin
        if (g == lo) break;
        hi = g - 1;
      end else if (g < tgt) begin
        if (g == hi) break;
        lo = g + 1;
      end else begin
        exp_found = 1; exp_res = g; break;
      end
    end
  endtask

  // comparator holding the target, answering after a random 0..2 cycle delay
  initial begin
    resp_valid = 0; smaller = 0; equal = 0; greater = 0;
    forever begin
      @(negedge clk);
      if (gv_en) begin
        resp_valid = 0; smaller = 0; equal = 0; greater = 0;
        if (guess_valid) begin
          if (dly > 0) dly--;
          else begin
            resp_valid = 1;
            dly = $urandom_range(0, 2);
            if (md == 0) begin
              smaller = int'(guess) < target;
              equal   = int'(guess) == target;
              greater = int'(guess) > target;
            end else if (md == 1) greater = 1;
            else begin smaller = 1; greater = 1; end
          end
        end
      end
    end
  end

  // compare process: each new guess against the model sequence, and the final outcome on done
  always @(negedge clk) begin
    if (!rst && guess_valid && !gv_prev) begin
      if (exp_q.size() == 0) check("extra_guess", int'(guess), -1);
      else check("guess", int'(guess), exp_q.pop_front());
    end
    if (!rst && done && !done_prev) begin
      check("found", int'(found), exp_found);
      check("err", int'(err), exp_err);
      check("result", int'(result), exp_res);
      check("iter_count", int'(iter_count), exp_n);
    end
    gv_prev = guess_valid;
    done_prev = done;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic run(input int tgt, input int mode);
    target = tgt; md = mode;
    model(tgt, mode);
    gv_en = 1;
    pulse_start();
    check("gv_issue_low", int'(guess_valid), 0);
    @(negedge clk);
    check("gv_latency", int'(guess_valid), 1);
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    check("done_reached", int'(done), 1);
    @(negedge clk);
    check("guesses_consumed", exp_q.size(), 0);
    check("done_held", int'(done), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_guess"}, int'(guess), 0);
    check({tag, "_gv"}, int'(guess_valid), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_found"}, int'(found), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_iter"}, int'(iter_count), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation hung");
  end

  initial begin
    int c;
    rst = 1; start = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    @(negedge clk);
    check_zero("idle");
    model(0, 0);
    check("model_n_t0", exp_n, 12);
    check("model_last_t0", exp_q[11], 0);
    model(4095, 0);
    check("model_n_t4095", exp_n, 13);
    check("model_last_t4095", exp_q[12], 4095);
    model(99, 0);
    check("model_first", exp_q[0], 2047);
    run(99, 0);
    check("t99_result", int'(result), 99);
    check("t99_found", int'(found), 1);
    run(0, 0);
    check("t0_iter", int'(iter_count), 12);
    run(4095, 0);
    check("t4095_iter", int'(iter_count), 13);
    run(1234, 2);
    check("illegal_err", int'(err), 1);
    check("illegal_iter", int'(iter_count), 1);
    run(500, 1);
    check("lying_found", int'(found), 0);
    check("lying_err", int'(err), 0);
    check("lying_guess", int'(guess), 0);
    for (int k = 0; k < 10; k++) run(int'($urandom_range(0, 4095)), 0);
    // reset while waiting, with a response arriving on the reset edge and one after it
    gv_en = 0;
    model(99, 0);
    pulse_start();
    for (int i = 0; i < 10 && !guess_valid; i++) @(negedge clk);
    check("rst_pre_gv", int'(guess_valid), 1);
    rst = 1; resp_valid = 1; equal = 1;
    @(negedge clk);
    check_zero("mid_rst");
    rst = 0;
    @(negedge clk);
    check_zero("late_resp");
    resp_valid = 0; equal = 0;
    exp_q.delete();
    run(2047, 0);
    check("after_rst_iter", int'(iter_count), 1);
    check("after_rst_result", int'(result), 2047);
`ifdef BSEARCH_TIMEOUT_EN
    gv_en = 0;
    model(99, 0);
    exp_n = 0; exp_err = 1; exp_found = 0; exp_res = 0;
    pulse_start();
    for (int i = 0; i < 10 && !guess_valid; i++) @(negedge clk);
    for (c = 0; c < 200 && !err; c++) @(negedge clk);
    check("timeout_cycles", c, TO);
    @(negedge clk);
    exp_q.delete();
`endif
    c = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
